// File: rtl/riscv_ctrl_pkg.sv
// Shared control-path types for the 5-stage pipeline: opcodes, ALU operation classes,
// per-stage control bundles and the helpers that narrow a bundle as it moves down the pipe.
package riscv_ctrl_pkg;

    localparam logic [6:0] OpcodeR     = 7'h33;
    localparam logic [6:0] OpcodeILogic = 7'h13;
    localparam logic [6:0] OpcodeLoad  = 7'h03;
    localparam logic [6:0] OpcodeJalr  = 7'h67;
    localparam logic [6:0] OpcodeStore = 7'h23;
    localparam logic [6:0] OpcodeBranch = 7'h63;
    localparam logic [6:0] OpcodeJal   = 7'h6F;
    localparam logic [6:0] OpcodeLui   = 7'h37;
    localparam logic [6:0] OpcodeAuipc = 7'h17;

    localparam int unsigned AluOpMinW = 4;

    typedef enum logic [3:0] {
        AluR      = 4'd0,
        AluI      = 4'd1,
        AluLoad   = 4'd2,
        AluJalr   = 4'd3,
        AluStore  = 4'd4,
        AluBranch = 4'd5,
        AluJal    = 4'd6,
        AluLui    = 4'd7,
        AluAuipc  = 4'd8
    } alu_op_e;

    // Full bundle as produced by decode and held in ID/EX.
    typedef struct packed {
        logic    jalr;
        logic    branch;
        logic    mem_to_reg;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    alu_src;
        alu_op_e alu_op;
    } ctrl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    // flags order: jalr, branch, mem_to_reg, reg_write, mem_read, mem_write, alu_src
    function automatic ctrl_t ctrl_row(input logic [6:0] flags, input alu_op_e alu_op);
        return ctrl_t'({flags, alu_op});
    endfunction

    function automatic mem_ctrl_t to_mem_ctrl(input ctrl_t c);
        mem_ctrl_t m;
        m.mem_read   = c.mem_read;
        m.mem_write  = c.mem_write;
        m.reg_write  = c.reg_write;
        m.mem_to_reg = c.mem_to_reg;
        return m;
    endfunction

    function automatic wb_ctrl_t to_wb_ctrl(input mem_ctrl_t m);
        wb_ctrl_t w;
        w.reg_write  = m.reg_write;
        w.mem_to_reg = m.mem_to_reg;
        return w;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control bundle, source-register usage and illegal flag.
module ctrl_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op_i,
    output ctrl_t      ctrl_o,
    output logic       use_rs1_o,
    output logic       use_rs2_o,
    output logic       illegal_o
);

    always_comb begin
        ctrl_o    = BUBBLE;
        use_rs1_o = 1'b0;
        use_rs2_o = 1'b0;
        illegal_o = 1'b0;
        unique case (op_i)
            OpcodeR: begin
                ctrl_o    = ctrl_row(7'b0001000, AluR);
                use_rs1_o = 1'b1;
                use_rs2_o = 1'b1;
            end
            OpcodeILogic: begin
                ctrl_o    = ctrl_row(7'b0001001, AluI);
                use_rs1_o = 1'b1;
            end
            OpcodeLoad: begin
                ctrl_o    = ctrl_row(7'b0011100, AluLoad);
                use_rs1_o = 1'b1;
            end
            OpcodeJalr: begin
                ctrl_o    = ctrl_row(7'b1001001, AluJalr);
                use_rs1_o = 1'b1;
            end
            OpcodeStore: begin
                ctrl_o    = ctrl_row(7'b0000011, AluStore);
                use_rs1_o = 1'b1;
                use_rs2_o = 1'b1;
            end
            OpcodeBranch: begin
                ctrl_o    = ctrl_row(7'b0100000, AluBranch);
                use_rs1_o = 1'b1;
                use_rs2_o = 1'b1;
            end
            OpcodeJal:   ctrl_o = ctrl_row(7'b0101001, AluJal);
            OpcodeLui:   ctrl_o = ctrl_row(7'b0001001, AluLui);
            OpcodeAuipc: ctrl_o = ctrl_row(7'b0001001, AluAuipc);
            default:     illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_control.sv
// Pipeline control: decodes ID, carries controls through ID/EX, EX/MEM, MEM/WB and inserts
// load-use / flush bubbles. Define PIPE_CTRL_PERF_CNT_EN to add bubble and flush counters.
module pipe_control
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned ALU_OP_W   = 4,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            OP_i,
    input  logic [REG_ADDR_W-1:0] Rs1_i,
    input  logic [REG_ADDR_W-1:0] Rs2_i,
    input  logic [REG_ADDR_W-1:0] Rd_i,
    input  logic                  Flush_i,
    input  logic                  Stall_i,
    output logic                  Load_Use_Stall_o,
    output logic                  Illegal_ID_o,
    output logic                  ALU_Src_EX_o,
    output logic                  JALR_EX_o,
    output logic                  Branch_EX_o,
    output logic [ALU_OP_W-1:0]   ALU_Op_EX_o,
    output logic [REG_ADDR_W-1:0] Rd_EX_o,
    output logic [REG_ADDR_W-1:0] Rd_MEM_o,
    output logic [REG_ADDR_W-1:0] Rd_WB_o,
    output logic                  Mem_Read_EX_o,
    output logic                  Mem_Read_MEM_o,
    output logic                  Mem_Write_MEM_o,
    output logic                  Reg_Write_MEM_o,
    output logic                  Reg_Write_WB_o,
    output logic                  Mem_to_Reg_WB_o
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]           Bubble_Count_o,
    output logic [31:0]           Flush_Count_o
`endif
);

    ctrl_t                 id_ctrl;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic                  id_illegal;

    ctrl_t                 ex_ctrl_q, ex_ctrl_d;
    logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
    mem_ctrl_t             mem_ctrl_q;
    logic [REG_ADDR_W-1:0] mem_rd_q;
    wb_ctrl_t              wb_ctrl_q;
    logic [REG_ADDR_W-1:0] wb_rd_q;

    logic                  load_use;
    logic                  rs1_match;
    logic                  rs2_match;

    ctrl_decode u_ctrl_decode (
        .op_i      (OP_i),
        .ctrl_o    (id_ctrl),
        .use_rs1_o (id_use_rs1),
        .use_rs2_o (id_use_rs2),
        .illegal_o (id_illegal)
    );

    // A load in EX whose result the ID instruction reads cannot be forwarded in time.
    always_comb begin
        rs1_match = id_use_rs1 && (Rs1_i == ex_rd_q);
        rs2_match = id_use_rs2 && (Rs2_i == ex_rd_q);
        load_use  = ex_ctrl_q.mem_read && (ex_rd_q != '0) && (rs1_match || rs2_match) &&
                    !Flush_i;
    end

    always_comb begin
        ex_ctrl_d = id_ctrl;
        ex_rd_d   = id_ctrl.reg_write ? Rd_i : '0;
        if (Flush_i || load_use) begin
            ex_ctrl_d = BUBBLE;
            ex_rd_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_ctrl_q  <= BUBBLE;
            ex_rd_q    <= '0;
            mem_ctrl_q <= '0;
            mem_rd_q   <= '0;
            wb_ctrl_q  <= '0;
            wb_rd_q    <= '0;
        end else if (!Stall_i) begin
            ex_ctrl_q  <= ex_ctrl_d;
            ex_rd_q    <= ex_rd_d;
            mem_ctrl_q <= to_mem_ctrl(ex_ctrl_q);
            mem_rd_q   <= ex_rd_q;
            wb_ctrl_q  <= to_wb_ctrl(mem_ctrl_q);
            wb_rd_q    <= mem_rd_q;
        end
    end

    assign Load_Use_Stall_o = load_use;
    assign Illegal_ID_o     = id_illegal;

    assign ALU_Src_EX_o    = ex_ctrl_q.alu_src;
    assign JALR_EX_o       = ex_ctrl_q.jalr;
    assign Branch_EX_o     = ex_ctrl_q.branch;
    assign ALU_Op_EX_o     = ALU_OP_W'(ex_ctrl_q.alu_op);
    assign Mem_Read_EX_o   = ex_ctrl_q.mem_read;
    assign Rd_EX_o         = ex_rd_q;

    assign Mem_Read_MEM_o  = mem_ctrl_q.mem_read;
    assign Mem_Write_MEM_o = mem_ctrl_q.mem_write;
    assign Reg_Write_MEM_o = mem_ctrl_q.reg_write;
    assign Rd_MEM_o        = mem_rd_q;

    assign Reg_Write_WB_o  = wb_ctrl_q.reg_write;
    assign Mem_to_Reg_WB_o = wb_ctrl_q.mem_to_reg;
    assign Rd_WB_o         = wb_rd_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] bubble_cnt_q;
    logic [31:0] flush_cnt_q;

    // load_use already excludes flush edges, so each edge bumps at most one counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else if (!Stall_i) begin
            if (Flush_i) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end else if (load_use) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign Bubble_Count_o = bubble_cnt_q;
    assign Flush_Count_o  = flush_cnt_q;
`endif

endmodule
